// File: rtl/rc4_keystream_ctrl_if.sv
// Keystream handshake and S-box RAM bus shared by the RC4 sequencer and its neighbours.
// The master side is the sequencer; the slave side is the consumer plus the RAM.
interface rc4_keystream_ctrl_if;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       mem_wen;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;

  modport master (
    output ks_data, ks_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    input  ks_ready, mem_rdata
  );

  modport slave (
    input  ks_data, ks_valid, mem_raddr, mem_wen, mem_waddr, mem_wdata,
    output ks_ready, mem_rdata
  );
endinterface

// File: rtl/rc4_keystream_ctrl.sv
// RC4 sequencer: fills the external S-box, runs key scheduling, then streams
// keystream bytes over a valid/ready handshake, one RAM access per cycle.
module rc4_keystream_ctrl #(
  parameter int KEY_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             key_len,
  input  logic [15:0]            msg_len,
  output logic                   busy,
  output logic                   done,
  rc4_keystream_ctrl_if.master   bus
);

  localparam logic [7:0] KEY_BYTES_W = 8'(KEY_BYTES);

  typedef enum logic [3:0] {
    IDLE, INIT,
    K_RI, K_RJ, K_W1, K_W2,
    P_CHK, P_RI, P_RJ, P_W1, P_W2, P_RT, P_CAP, P_OUT
  } state_t;

  state_t                 state, state_next;
  logic [7:0]             i, j, si, sj, t;
  logic [7:0]             kidx, klen;
  logic [15:0]            cnt, msg_len_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             key_byte;
  logic [7:0]             eff_len;
  logic [7:0]             j_ksa, j_prga;

  assign eff_len = (key_len == 8'd0 || key_len > KEY_BYTES_W) ? KEY_BYTES_W : key_len;
  assign j_ksa   = j + bus.mem_rdata + key_byte;
  assign j_prga  = j + bus.mem_rdata;

  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kidx == 8'(n)) key_byte = key_q[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Each state issues at most one read and one write; read data arrives in the following state.
  always_comb begin
    state_next    = state;
    bus.mem_raddr = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: if (start) state_next = INIT;
      INIT: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = i;
        bus.mem_wdata = i;
        if (i == 8'hFF) state_next = K_RI;
      end
      K_RI: begin
        bus.mem_raddr = i;
        state_next    = K_RJ;
      end
      K_RJ: begin
        bus.mem_raddr = j_ksa;
        state_next    = K_W1;
      end
      K_W1: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = j;
        bus.mem_wdata = si;
        state_next    = K_W2;
      end
      K_W2: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = i;
        bus.mem_wdata = sj;
        state_next    = (i == 8'hFF) ? P_CHK : K_RI;
      end
      P_CHK: state_next = (cnt == msg_len_q) ? IDLE : P_RI;
      P_RI: begin
        bus.mem_raddr = i + 8'd1;
        state_next    = P_RJ;
      end
      P_RJ: begin
        bus.mem_raddr = j_prga;
        state_next    = P_W1;
      end
      P_W1: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = j;
        bus.mem_wdata = si;
        state_next    = P_W2;
      end
      P_W2: begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = i;
        bus.mem_wdata = sj;
        state_next    = P_RT;
      end
      P_RT: begin
        bus.mem_raddr = t;
        state_next    = P_CAP;
      end
      P_CAP: state_next = P_OUT;
      P_OUT: if (bus.ks_ready) state_next = P_CHK;
      default: state_next = IDLE;
    endcase
  end

  // Index, swap and handshake registers; i wraps to 0 naturally after 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.ks_valid <= 1'b0;
      bus.ks_data  <= '0;
      i            <= '0;
      j            <= '0;
      si           <= '0;
      sj           <= '0;
      t            <= '0;
      kidx         <= '0;
      klen         <= '0;
      cnt          <= '0;
      msg_len_q    <= '0;
      key_q        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          key_q     <= key;
          klen      <= eff_len;
          msg_len_q <= msg_len;
          i         <= '0;
          j         <= '0;
          kidx      <= '0;
          cnt       <= '0;
          busy      <= 1'b1;
        end
        INIT: begin
          i <= i + 8'd1;
          if (i == 8'hFF) begin
            j    <= '0;
            kidx <= '0;
          end
        end
        K_RJ: begin
          si <= bus.mem_rdata;
          j  <= j_ksa;
        end
        K_W1: sj <= bus.mem_rdata;
        K_W2: begin
          kidx <= (kidx == klen - 8'd1) ? 8'd0 : kidx + 8'd1;
          i    <= i + 8'd1;
          if (i == 8'hFF) j <= '0;
        end
        P_CHK: if (cnt == msg_len_q) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        P_RI: i <= i + 8'd1;
        P_RJ: begin
          si <= bus.mem_rdata;
          j  <= j_prga;
        end
        P_W1: sj <= bus.mem_rdata;
        P_W2: t  <= si + sj;
        P_CAP: begin
          bus.ks_data  <= bus.mem_rdata;
          bus.ks_valid <= 1'b1;
        end
        P_OUT: if (bus.ks_ready) begin
          bus.ks_valid <= 1'b0;
          cnt          <= cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_keystream_ctrl.sv
// Bench for rc4_keystream_ctrl: behavioural RAM, RC4 reference model and a
// scoreboard queue drained by a monitor whenever a keystream byte is handed over.
module tb_rc4_keystream_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] key;
  logic [7:0]  key_len;
  logic [15:0] msg_len;
  logic        busy;
  logic        done;

  rc4_keystream_ctrl_if bus();

  rc4_keystream_ctrl #(.KEY_BYTES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .key_len (key_len),
    .msg_len (msg_len),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  logic [7:0] ram [256];
  logic [7:0] exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   job_on = 0;
  int   seen_valid = 0;
  int   done_cnt = 0;
  int   job_finished = 0;
  int   exp_done_rel = -1;
  int   recv = 0;
  int   ready_mode = 1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_done = 1'b0;
  logic [7:0] prev_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Synchronous-read RAM; a same-address read and write returns the old byte.
  always @(posedge clk) begin
    bus.mem_rdata <= ram[bus.mem_raddr];
    if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
  end

  initial begin
    bus.ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ks_ready = (ready_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
    end
  endtask

  // Plain RC4 over an integer array.
  task automatic pushRef(input logic [31:0] k, input int kl, input int n);
    int s [256];
    int ii, jj, tmp, len;
    len = (kl == 0 || kl > 4) ? 4 : kl;
    for (int x = 0; x < 256; x++) s[x] = x;
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj    = (jj + s[x] + int'(k[8*(x % len) +: 8])) % 256;
      tmp   = s[x];
      s[x]  = s[jj];
      s[jj] = tmp;
    end
    ii = 0;
    jj = 0;
    for (int m = 0; m < n; m++) begin
      ii    = (ii + 1) % 256;
      jj    = (jj + s[ii]) % 256;
      tmp   = s[ii];
      s[ii] = s[jj];
      s[jj] = tmp;
      exp_q.push_back(8'(s[(s[ii] + s[jj]) % 256]));
    end
  endtask

  task automatic pushKeyVector();
    logic [7:0] v [10];
    v = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    foreach (v[n]) exp_q.push_back(v[n]);
  endtask

  task automatic pushWikiVector();
    logic [7:0] v [6];
    v = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
    foreach (v[n]) exp_q.push_back(v[n]);
  endtask

  task automatic applyStimulus(input logic [31:0] k, input logic [7:0] kl,
                               input logic [15:0] ml, input int rmode, input int done_rel);
    @(posedge clk);
    #1;
    ready_mode   = rmode;
    key          = k;
    key_len      = kl;
    msg_len      = ml;
    start        = 1'b1;
    seen_valid   = 0;
    done_cnt     = 0;
    job_finished = 0;
    recv         = 0;
    exp_done_rel = done_rel;
    @(posedge clk);
    #1;
    start   = 1'b0;
    t0      = cyc;
    job_on  = 1;
    key     = $urandom;
    key_len = 8'($urandom_range(0, 255));
    msg_len = 16'($urandom_range(0, 65535));
  endtask

  task automatic waitDone(input int budget, input int inject);
    int injected_out;
    injected_out = 0;
    for (int c = 0; c < budget && job_finished == 0; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inject != 0 && c == 600) start = 1'b1;
      if (inject != 0 && injected_out == 0 && bus.ks_valid) begin
        start        = 1'b1;
        injected_out = 1;
      end
    end
    start = 1'b0;
    checkOutput("job_done", job_finished, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", done_cnt, 1);
    job_on = 0;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int   rel;
    logic [7:0] want;
    rel = cyc - t0;
    if (!rst) begin
      if (job_on != 0) begin
        if (rel == 0) checkOutput("busy_rise", int'(busy), 1);
        if (bus.ks_valid && seen_valid == 0) begin
          checkOutput("first_valid_latency", rel, 1287);
          seen_valid = 1;
        end
        if (exp_done_rel >= 0 && rel == exp_done_rel - 1)
          checkOutput("busy_before_done", int'(busy), 1);
      end
      if (done) begin
        done_cnt++;
        checkOutput("done_width", int'(prev_done), 0);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("queue_drained", exp_q.size(), 0);
        if (exp_done_rel >= 0) begin
          checkOutput("done_time", rel, exp_done_rel);
          checkOutput("no_bytes_for_empty_msg", seen_valid, 0);
        end
        job_finished = 1;
      end
      if (prev_valid && !prev_ready) begin
        checkOutput("hold_valid", int'(bus.ks_valid), 1);
        checkOutput("hold_data", int'(bus.ks_data), int'(prev_data));
      end
      if (bus.ks_valid && bus.ks_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_byte: got %0h want no byte", bus.ks_data);
        end else begin
          want = exp_q.pop_front();
          checkOutput("ks_byte", int'(bus.ks_data), int'(want));
          recv++;
        end
      end
      prev_valid = bus.ks_valid;
      prev_ready = bus.ks_ready;
      prev_data  = bus.ks_data;
      prev_done  = done;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_ks_valid"}, int'(bus.ks_valid), 0);
    checkOutput({tag, "_ks_data"}, int'(bus.ks_data), 0);
    checkOutput({tag, "_mem_wen"}, int'(bus.mem_wen), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic [31:0] rk;
    logic [7:0]  rkl;
    int          rn;
    rst     = 1'b1;
    start   = 1'b0;
    key     = '0;
    key_len = '0;
    msg_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;

    $display("[TB] Key vector, consumer always ready");
    pushKeyVector();
    applyStimulus(32'h0079654B, 8'd3, 16'd10, 1, -1);
    waitDone(1800, 0);

    $display("[TB] Wiki vector, random back-pressure");
    pushWikiVector();
    applyStimulus(32'h696B6957, 8'd4, 16'd6, 0, -1);
    waitDone(2200, 0);

    $display("[TB] Wiki vector, key_len 0 clamps to full key");
    pushWikiVector();
    applyStimulus(32'h696B6957, 8'd0, 16'd6, 0, -1);
    waitDone(2200, 0);

    $display("[TB] empty message");
    applyStimulus(32'h0079654B, 8'd3, 16'd0, 1, 1281);
    waitDone(1500, 0);

    $display("[TB] start pulses during KSA and P_OUT are ignored");
    pushWikiVector();
    applyStimulus(32'h696B6957, 8'd4, 16'd6, 0, -1);
    waitDone(2200, 1);

    $display("[TB] reset in the middle of PRGA");
    pushKeyVector();
    applyStimulus(32'h0079654B, 8'd3, 16'd10, 1, -1);
    for (int c = 0; c < 2000 && recv < 3; c++) @(posedge clk);
    checkOutput("reached_prga", int'(recv >= 3), 1);
    #1;
    rst    = 1'b1;
    job_on = 0;
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("midreset");
    exp_q.delete();
    rst = 1'b0;
    pushKeyVector();
    applyStimulus(32'h0079654B, 8'd3, 16'd10, 1, -1);
    waitDone(1800, 0);

    $display("[TB] random keys against the reference model");
    for (int r = 0; r < 3; r++) begin
      rk  = $urandom;
      rkl = 8'($urandom_range(0, 6));
      rn  = $urandom_range(1, 5);
      pushRef(rk, int'(rkl), rn);
      applyStimulus(rk, rkl, 16'(rn), 0, -1);
      waitDone(2000, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
